// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-to-ALU bridge.
// Holds the frame tag bytes, the one-hot FSM state encoding and the default
// parameter values used by uart_alu_bridge and uart_rx_timer.
package uart_alu_pkg;

  // Default parameter values
  localparam int unsigned NbDataDefault  = 8;
  localparam int unsigned NbOpDefault    = 6;
  localparam int unsigned ResLatDefault  = 1;
  localparam int unsigned TimeoutDefault = 1000;

  // Frame tag bytes, compared on the full byte width
  localparam int unsigned TagA  = 32'h08;
  localparam int unsigned TagB  = 32'h10;
  localparam int unsigned TagOp = 32'h20;

  // One-hot FSM encoding
  typedef enum logic [4:0] {
    StIdle        = 5'b00001,
    StWaitPayload = 5'b00010,
    StExec        = 5'b00100,
    StSend        = 5'b01000,
    StWaitTx      = 5'b10000
  } state_e;

endpackage

// File: rtl/uart_rx_timer.sv
// Idle-cycle timer for the payload wait of uart_alu_bridge.
// Ports:
//   clk       clock
//   i_rst_n   asynchronous active-low reset
//   i_clear   restart the count from zero
//   i_enable  count this cycle
//   o_expired high in the enabled cycle that reaches TIMEOUT counted cycles
module uart_rx_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [15:0] cnt_q;

  assign o_expired = i_enable && (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clear || o_expired) begin
      cnt_q <= '0;
    end else if (i_enable) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/uart_alu_bridge.sv
// Bridge between a byte-oriented UART and a combinational/pipelined ALU.
// Two-byte frames (tag, payload) load operand A, operand B or the op code;
// an op-code frame strobes the ALU, captures its result RES_LAT cycles later
// and sends it back through the UART transmitter.
// Ports:
//   clk, i_rst_n            clock, asynchronous active-low reset
//   i_rx, i_rxDone          received byte and its one-cycle valid pulse
//   i_txDone                one-cycle pulse, transmitted byte finished
//   i_result                ALU result
//   o_datoA, o_datoB        ALU operands
//   o_operation             ALU op code
//   o_valid                 one-cycle ALU strobe
//   o_tx_start, o_data      one-cycle TX request and the byte to send
//   o_busy                  high while executing or transmitting
//   o_err                   one-cycle error pulse (bad tag, dropped byte, timeout)
// Optional feature: define UART_ALU_BRIDGE_TIMEOUT_EN to abandon a tag whose
// payload does not arrive within TIMEOUT cycles.
module uart_alu_bridge
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DATA = NbDataDefault,
  parameter int unsigned NB_OP   = NbOpDefault,
  parameter int unsigned RES_LAT = ResLatDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx,
  input  logic               i_rxDone,
  input  logic               i_txDone,
  input  logic [NB_DATA-1:0] i_result,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_busy,
  output logic               o_err
);

  localparam bit ParamsOk = (NB_OP <= NB_DATA) && (RES_LAT <= 15) &&
                            (TIMEOUT >= 1) && (TIMEOUT <= 65535);

  if (!ParamsOk) begin : g_param_check
    $error("uart_alu_bridge: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] tag_q, tag_d;
  logic [NB_DATA-1:0] dato_a_q, dato_a_d;
  logic [NB_DATA-1:0] dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [3:0]         lat_q, lat_d;
  logic               err_q, err_d;
  logic               rx_is_tag;
  logic               timeout_hit;

  assign rx_is_tag = (i_rx == NB_DATA'(TagA)) || (i_rx == NB_DATA'(TagB)) ||
                     (i_rx == NB_DATA'(TagOp));

`ifdef UART_ALU_BRIDGE_TIMEOUT_EN
  logic in_wait_payload;

  assign in_wait_payload = (state_q == StWaitPayload);

  // A received payload restarts the count; leaving the state clears it.
  uart_rx_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_rx_timer (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (!in_wait_payload || i_rxDone),
    .i_enable (in_wait_payload && !i_rxDone),
    .o_expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    dato_a_d = dato_a_q;
    dato_b_d = dato_b_q;
    op_d     = op_q;
    data_d   = data_q;
    lat_d    = lat_q;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_rxDone) begin
          if (rx_is_tag) begin
            tag_d   = i_rx;
            state_d = StWaitPayload;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWaitPayload: begin
        if (i_rxDone) begin
          tag_d = '0;
          if (tag_q == NB_DATA'(TagA)) begin
            dato_a_d = i_rx;
            state_d  = StIdle;
          end else if (tag_q == NB_DATA'(TagB)) begin
            dato_b_d = i_rx;
            state_d  = StIdle;
          end else begin
            op_d    = i_rx[NB_OP-1:0];
            lat_d   = '0;
            state_d = StExec;
          end
        end else if (timeout_hit) begin
          tag_d   = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StExec: begin
        err_d = i_rxDone;
        // lat_q counts cycles since the o_valid cycle (lat_q == 0)
        if (lat_q == 4'(RES_LAT)) begin
          data_d  = i_result;
          lat_d   = '0;
          state_d = StSend;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      StSend: begin
        err_d   = i_rxDone;
        state_d = StWaitTx;
      end
      StWaitTx: begin
        err_d = i_rxDone;
        if (i_txDone) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      tag_q    <= '0;
      dato_a_q <= '0;
      dato_b_q <= '0;
      op_q     <= '0;
      data_q   <= '0;
      lat_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      dato_a_q <= dato_a_d;
      dato_b_q <= dato_b_d;
      op_q     <= op_d;
      data_q   <= data_d;
      lat_q    <= lat_d;
      err_q    <= err_d;
    end
  end

  assign o_datoA     = dato_a_q;
  assign o_datoB     = dato_b_q;
  assign o_operation = op_q;
  assign o_data      = data_q;
  assign o_valid     = (state_q == StExec) && (lat_q == 4'd0);
  assign o_tx_start  = (state_q == StSend);
  assign o_busy      = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx);
  assign o_err       = err_q;

endmodule
